temp_control_fsm: RTL

Greenhouse climate controller that produces the 2-bit temperature status consumed by the VGA status panel, along with the heater and cooler enables that drive the relay outputs. It samples temperature readings from the sensor interface and applies hysteresis around a setpoint. It enforces a minimum dwell time per mode and flags sensor faults or timeouts as an error. It sits between the sensor reader and both the actuator outputs and the display pipeline.

---
 rtl/temp_control_fsm_if.sv | 24 ++
 rtl/temp_control_fsm.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/temp_control_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// temp_control_fsm_if : sensor sample bus plus status/actuator returns
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
interface temp_control_fsm_if;
  logic       temp_valid;
  logic [7:0] temp_c;
  logic [7:0] setpoint;
  logic [1:0] status;
  logic       heater_en;
  logic       cooler_en;

  modport master (
    output temp_valid, temp_c, setpoint,
    input  status, heater_en, cooler_en
  );

  modport slave (
    input  temp_valid, temp_c, setpoint,
    output status, heater_en, cooler_en
  );
endinterface
`default_nettype wire

// File: rtl/temp_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// temp_control_fsm : hysteresis heat/cool controller with dwell, watchdog, error
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
module temp_control_fsm #(
  parameter int unsigned HYST      = 2,
  parameter int unsigned MIN_DWELL = 50_000_000,
  parameter int unsigned TIMEOUT   = 100_000_000,
  parameter int unsigned ERR_CLEAR = 3
) (
  input wire logic          clk,
  input wire logic          reset,
  temp_control_fsm_if.slave bus
);

  localparam int unsigned c_dw_w   = $clog2(MIN_DWELL + 1);
  localparam int unsigned c_wd_w   = $clog2(TIMEOUT + 1);
  localparam int unsigned c_good_w = $clog2(ERR_CLEAR + 1);

  localparam logic [c_dw_w-1:0]   c_dwell_max = c_dw_w'(MIN_DWELL);
  localparam logic [c_wd_w-1:0]   c_wd_max    = c_wd_w'(TIMEOUT);
  localparam logic [c_wd_w-1:0]   c_wd_last   = c_wd_w'(TIMEOUT - 1);
  localparam logic [c_good_w-1:0] c_good_last = c_good_w'(ERR_CLEAR - 1);
  localparam logic [8:0]          c_hyst      = 9'(HYST);

  // Encoding doubles as the status code seen by the display pipeline.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HEAT  = 2'b01,
    ST_COOL  = 2'b10,
    ST_ERROR = 2'b11
  } state_t;

  state_t              state_q, state_d;
  logic [c_dw_w-1:0]   dwell_q, dwell_d;
  logic [c_wd_w-1:0]   wd_q, wd_d;
  logic [c_good_w-1:0] good_cnt_q, good_cnt_d;
  logic [1:0]          status_q;
  logic                heater_en_q;
  logic                cooler_en_q;

  logic       w_good;
  logic       w_fault;
  logic       w_timeout;
  logic       w_dwell_done;
  logic [8:0] w_sp9;
  logic [8:0] w_temp9;
  logic [8:0] w_lo;
  logic [8:0] w_hi;

  always_comb begin
    w_sp9        = {1'b0, bus.setpoint};
    w_temp9      = {1'b0, bus.temp_c};
    w_lo         = (w_sp9 >= c_hyst) ? (w_sp9 - c_hyst) : 9'd0;
    w_hi         = w_sp9 + c_hyst;
    if (w_hi > 9'd255) begin
      w_hi = 9'd255;
    end

    w_good       = bus.temp_valid && (bus.temp_c != 8'hFF);
    w_fault      = bus.temp_valid && (bus.temp_c == 8'hFF);
    // A strobe on the would-be timeout cycle wins over the watchdog.
    w_timeout    = !bus.temp_valid && (wd_q >= c_wd_last);
    w_dwell_done = (dwell_q == c_dwell_max);

    if (bus.temp_valid) begin
      wd_d = '0;
    end else if (wd_q == c_wd_max) begin
      wd_d = wd_q;
    end else begin
      wd_d = wd_q + c_wd_w'(1);
    end

    state_d    = state_q;
    good_cnt_d = good_cnt_q;

    if (w_fault || w_timeout) begin
      state_d    = ST_ERROR;
      good_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_good && w_dwell_done) begin
            if (w_temp9 < w_lo) begin
              state_d = ST_HEAT;
            end else if (w_temp9 > w_hi) begin
              state_d = ST_COOL;
            end
          end
        end
        ST_HEAT: begin
          if (w_good && w_dwell_done && (w_temp9 >= w_sp9)) begin
            state_d = ST_IDLE;
          end
        end
        ST_COOL: begin
          if (w_good && w_dwell_done && (w_temp9 <= w_sp9)) begin
            state_d = ST_IDLE;
          end
        end
        ST_ERROR: begin
          if (w_good) begin
            if (good_cnt_q == c_good_last) begin
              state_d    = ST_IDLE;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + c_good_w'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (state_d != state_q) begin
      dwell_d = '0;
    end else if (w_dwell_done) begin
      dwell_d = dwell_q;
    end else begin
      dwell_d = dwell_q + c_dw_w'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dwell_q     <= c_dwell_max;
      wd_q        <= '0;
      good_cnt_q  <= '0;
      status_q    <= 2'b00;
      heater_en_q <= 1'b0;
      cooler_en_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      wd_q        <= wd_d;
      good_cnt_q  <= good_cnt_d;
      status_q    <= state_d;
      heater_en_q <= (state_d == ST_HEAT);
      cooler_en_q <= (state_d == ST_COOL);
    end
  end

  assign bus.status    = status_q;
  assign bus.heater_en = heater_en_q;
  assign bus.cooler_en = cooler_en_q;

endmodule
`default_nettype wire
